// File: rtl/sseg_pkg.sv
// Shared types, segment tables and the pattern decoder for the 7-segment snoop path.
// Segment patterns are active low and ordered {a,b,c,d,e,f,g}; the decimal point is handled separately.
package sseg_pkg;

    typedef logic [6:0] seg7_t;

    // Result of decoding one digit pattern.
    typedef struct packed {
        logic [3:0] nibble;
        logic       is_blank;
        logic       is_valid;
    } seg_dec_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t SEG_HEX [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0001100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Map a segment pattern back to its hex nibble; a dark digit decodes as nibble 0 with is_blank set.
    function automatic seg_dec_t decode(input seg7_t pattern);
        seg_dec_t r;
        r.nibble   = 4'h0;
        r.is_blank = 1'b0;
        r.is_valid = 1'b0;
        if (pattern == SEG_BLANK) begin
            r.is_blank = 1'b1;
            r.is_valid = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pattern == SEG_HEX[i]) begin
                    r.nibble   = 4'(i);
                    r.is_valid = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sseg_digit_decode.sv
// Combinational wrapper around the package decoder so one digit pattern can be decoded as a block.
module sseg_digit_decode
    import sseg_pkg::*;
(
    input  seg7_t      pattern,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_valid
);

    seg_dec_t dec;

    // Pure table lookup, no state.
    always_comb begin
        dec      = decode(pattern);
        nibble   = dec.nibble;
        is_blank = dec.is_blank;
        is_valid = dec.is_valid;
    end

endmodule

// File: rtl/sseg_capture.sv
// Receive side of a multiplexed active-low 7-segment bus: qualifies each digit dwell, decodes it and
// rebuilds the full display word. A frame is published only once every digit has been captured cleanly.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     dp,
    output logic                  valid,
    output logic                  err
);

    localparam int            CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);

    logic [7:0]          seg_s, seg_p;
    logic [DIGITS-1:0]   an_s, an_p;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] sh_value;
    logic [DIGITS-1:0]   sh_blank;
    logic [DIGITS-1:0]   sh_dp;

    logic [DIGITS-1:0]   sel;
    logic                sel_ok;
    logic                same;
    logic                capture;
    logic                frame_full;
    logic                publish;
    logic [3:0]          dec_nibble;
    logic                dec_blank;
    logic                dec_ok;

    // Stage-0 sample of the bus plus a one-cycle-old copy for the stability compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s <= 8'hFF;
            an_s  <= '1;
            seg_p <= 8'hFF;
            an_p  <= '1;
        end else begin
            seg_s <= seg;
            an_s  <= an;
            seg_p <= seg_s;
            an_p  <= an_s;
        end
    end

    // Select qualification and capture strobe; exactly one active-low enable is a usable dwell.
    always_comb begin
        sel        = ~an_s;
        sel_ok     = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
        same       = (seg_s == seg_p) && (an_s == an_p);
        capture    = sel_ok && same && (cnt == CNT_FIRE);
        frame_full = &seen;
        publish    = frame_full && !capture;
    end

    sseg_digit_decode u_decode (
        .pattern  (seg_s[7:1]),
        .nibble   (dec_nibble),
        .is_blank (dec_blank),
        .is_valid (dec_ok)
    );

    // Dwell counter: counts identical samples, saturates so capture fires once per dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (sel_ok && same) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    // Frame assembly: shadow digit slots and the mask of digits seen in this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen     <= '0;
            sh_value <= '0;
            sh_blank <= '1;
            sh_dp    <= '0;
        end else if (capture) begin
            if (dec_ok) begin
                seen <= seen | sel;
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i]) begin
                        sh_value[4*i +: 4] <= dec_nibble;
                        sh_blank[i]        <= dec_blank;
                        sh_dp[i]           <= ~seg_s[0];
                    end
                end
            end else begin
                // A corrupt dwell poisons the whole frame.
                seen <= '0;
            end
        end else if (frame_full) begin
            seen <= '0;
        end
    end

    // Published word and status pulses; the output word only moves on a clean frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            blank <= '1;
            dp    <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= publish;
            err   <= capture && !dec_ok;
            if (publish) begin
                value <= sh_value;
                blank <= sh_blank;
                dp    <= sh_dp;
            end
        end
    end

endmodule
